sw_debounce: RTL

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 77 +++++++
 1 files changed

// File: rtl/sw_debounce.sv
// Three-channel switch debouncer: 2-flop synchronizer, per-channel stability counter, optional rising-edge press pulse.
// Build option: define SW_DEBOUNCE_PRESS_EN to build the press-pulse flops; otherwise press is tied low.
module sw_debounce #(
    parameter int unsigned CNT_WIDTH  = 20,
    parameter int unsigned STABLE_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw0,
    input  logic       sw1,
    input  logic       sw2,
    output logic [2:0] db,
    output logic [2:0] press
);

    localparam int unsigned N_CH = 3;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CNT - 1);

    logic [N_CH-1:0]                sw_raw;
    logic [N_CH-1:0]                s1;
    logic [N_CH-1:0]                s2;
    logic [N_CH-1:0][CNT_WIDTH-1:0] cnt;
    logic [N_CH-1:0][CNT_WIDTH-1:0] cnt_nxt;
    logic [N_CH-1:0]                db_nxt;

    assign sw_raw = {sw2, sw1, sw0};

    // Metastability guard; only s2 feeds the debounce logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

    // A mismatch must persist STABLE_CNT cycles before db follows; any match clears the count.
    always_comb begin
        cnt_nxt = '0;
        db_nxt  = db;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (s2[i] != db[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    db_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            db  <= '0;
        end else begin
            cnt <= cnt_nxt;
            db  <= db_nxt;
        end
    end

`ifdef SW_DEBOUNCE_PRESS_EN
    // Registered alongside db so the pulse coincides with the first high cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press <= '0;
        end else begin
            press <= db_nxt & ~db;
        end
    end
`else
    assign press = '0;
`endif

endmodule
